// File: rtl/mc_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch, decode, execute, memory, writeback.
// Moore-decoded controls; FETCH/MEMRD/MEMWR stall on MemReady, and only IRWrite/PCWrite follow it in FETCH.
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       InstrDone,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  state_t state_q, state_d;
  logic   pc_write_raw, ir_write_raw, instr_done_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = FETCH;
    pc_write_raw   = 1'b0;
    ir_write_raw   = 1'b0;
    instr_done_raw = 1'b0;
    PCWriteCond    = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    MemtoReg       = 1'b0;
    RegWrite       = 1'b0;
    RegDst         = 1'b0;
    ALUSrcA        = 1'b0;
    ALUOp          = 2'b00;
    ALUSrcB        = 2'b00;
    PCSource       = 2'b00;
    Illegal        = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead      = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
        state_d      = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_RTYPE:         state_d = EXEC;
          OP_BEQ:           state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_ADDI, OP_ANDI: state_d = IEXEC;
          default: begin
            Illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Op == OP_LW)      state_d = MEMRD;
        else if (Op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite       = 1'b1;
        MemtoReg       = 1'b1;
        instr_done_raw = 1'b1;
      end
      MEMWR: begin
        MemWrite       = 1'b1;
        IorD           = 1'b1;
        instr_done_raw = MemReady;
        state_d        = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite       = 1'b1;
        RegDst         = 1'b1;
        instr_done_raw = 1'b1;
      end
      BRANCH: begin
        ALUSrcA        = 1'b1;
        ALUOp          = 2'b01;
        PCWriteCond    = 1'b1;
        PCSource       = 2'b01;
        instr_done_raw = 1'b1;
      end
      JUMP: begin
        pc_write_raw   = 1'b1;
        PCSource       = 2'b10;
        instr_done_raw = 1'b1;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (Op == OP_ANDI) ? 2'b11 : 2'b00;
        state_d = IWB;
      end
      IWB: begin
        RegWrite       = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset holds State at FETCH, so only the MemReady-driven strobes need masking
  assign PCWrite   = pc_write_raw & rst_n;
  assign IRWrite   = ir_write_raw & rst_n;
  assign InstrDone = instr_done_raw & rst_n;
  assign State     = state_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed literal state sequences, async reset, then random instruction stream.
module tb_mc_main_control;

  logic       clk, rst_n;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegWrite, RegDst, ALUSrcA, InstrDone, Illegal;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;
  int dir_st[$];
  bit dir_mr[$];

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .State(State), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] J_OP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100;

  function automatic bit supported(input logic [5:0] op);
    return op inside {R_OP, LW, SW, BEQ, J_OP, ADDI, ANDI};
  endfunction

  // Control word for a state, taken straight from the per-state output table.
  function automatic logic [17:0] exp_out(input int st, input logic [5:0] op, input bit mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, done, ill;
    logic [1:0] aluop, srcb, pcsrc;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, done, ill} = '0;
    aluop = 2'b00; srcb = 2'b00; pcsrc = 2'b00;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  begin srcb = 2'b11; ill = !supported(op); end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; iord = 1; done = mr; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; done = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; done = 1; end
      9:  begin pcw = 1; pcsrc = 2'b10; done = 1; end
      10: begin srca = 1; srcb = 2'b10; aluop = (op == ANDI) ? 2'b11 : 2'b00; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, aluop, srcb, pcsrc, done, ill};
  endfunction

  function automatic logic [17:0] dut_out();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
            RegDst, ALUSrcA, ALUOp, ALUSrcB, PCSource, InstrDone, Illegal};
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic [17:0] ctl);
    checks++;
    if ({State, dut_out()} !== {st, ctl}) begin
      failures++;
      $display("FAIL %s t=%0t: got State=%0d ctl=%h, want State=%0d ctl=%h",
               name, $time, State, dut_out(), st, ctl);
    end
  endtask

  task automatic step(input int st, input logic [5:0] drv_op, input logic [5:0] mdl_op,
                      input bit mr, input string name);
    @(negedge clk);
    Op = drv_op;
    MemReady = mr;
    #1;
    check(name, st[3:0], exp_out(st, mdl_op, mr));
  endtask

  task automatic run_dir(input string name, input logic [5:0] op);
    for (int i = 0; i < dir_st.size(); i++) step(dir_st[i], op, op, dir_mr[i], name);
  endtask

  // Abstract path of one instruction after FETCH, expanded with memory stall cycles.
  task automatic run_random(input logic [5:0] op, input int sf, input int sm);
    int path[$];
    logic [5:0] d;
    if (op == R_OP)                   path = '{1, 6, 7};
    else if (op == LW)                path = '{1, 2, 3, 4};
    else if (op == SW)                path = '{1, 2, 5};
    else if (op == BEQ)               path = '{1, 8};
    else if (op == J_OP)              path = '{1, 9};
    else if (op == ADDI || op == ANDI) path = '{1, 10, 11};
    else                              path = '{1};
    for (int i = 0; i < sf; i++) step(0, 6'($urandom), op, 1'b0, "rnd_fetch_stall");
    step(0, 6'($urandom), op, 1'b1, "rnd_fetch");
    foreach (path[k]) begin
      d = (path[k] inside {1, 2, 10}) ? op : 6'($urandom);
      if (path[k] == 3 || path[k] == 5) begin
        for (int i = 0; i < sm; i++) step(path[k], d, op, 1'b0, "rnd_mem_stall");
        step(path[k], d, op, 1'b1, "rnd_mem");
      end else begin
        step(path[k], d, op, 1'($urandom), "rnd_path");
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    int r;
    rst_n = 1'b0; MemReady = 1'b0; Op = 6'd0;
    #1;
    check("reset_state", 4'd0, exp_out(0, 6'd0, 1'b0));
    MemReady = 1'b1;
    #1;
    check("reset_strobes_masked", 4'd0, exp_out(0, 6'd0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    MemReady = 1'b0;
    rst_n = 1'b1;

    dir_st = '{0, 1, 6, 7, 0};                        dir_mr = '{1, 1, 1, 1, 0};
    run_dir("rtype_seq", R_OP);
    dir_st = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};      dir_mr = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
    run_dir("lw_stall_seq", LW);
    dir_st = '{0, 1, 8, 0};                           dir_mr = '{1, 1, 1, 0};
    run_dir("beq_seq", BEQ);
    dir_st = '{0, 1, 10, 11, 0};                      dir_mr = '{1, 1, 1, 1, 0};
    run_dir("andi_seq", ANDI);
    run_dir("addi_seq", ADDI);
    dir_st = '{0, 1, 0};                              dir_mr = '{1, 1, 0};
    run_dir("illegal_seq", 6'b111111);
    dir_st = '{0, 1, 2, 5, 5, 0};                     dir_mr = '{1, 1, 1, 0, 1, 0};
    run_dir("sw_seq", SW);
    dir_st = '{0, 1, 9, 0};                           dir_mr = '{1, 1, 1, 0};
    run_dir("j_seq", J_OP);

    // Asynchronous reset while in EXEC
    step(0, R_OP, R_OP, 1'b1, "rst_pre_fetch");
    step(1, R_OP, R_OP, 1'b1, "rst_pre_decode");
    step(6, R_OP, R_OP, 1'b1, "rst_pre_exec");
    rst_n = 1'b0;
    #1;
    check("rst_async_exec", 4'd0, exp_out(0, R_OP, 1'b0));
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    check("rst_hold_edge", 4'd0, exp_out(0, R_OP, 1'b0));
    rst_n = 1'b1;
    #1;
    check("rst_release_fetch", 4'd0, exp_out(0, R_OP, 1'b1));
    @(posedge clk);
    #1;
    check("rst_first_edge", 4'd1, exp_out(1, R_OP, 1'b1));
    step(1, R_OP, R_OP, 1'b1, "rst_post_decode");
    step(6, R_OP, R_OP, 1'b1, "rst_post_exec");
    step(7, R_OP, R_OP, 1'b1, "rst_post_aluwb");

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 8);
      case (r)
        0: op = R_OP;  1: op = LW;   2: op = SW;  3: op = BEQ;
        4: op = J_OP;  5: op = ADDI; 6: op = ANDI;
        default: op = 6'($urandom);
      endcase
      run_random(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end
    step(0, 6'd0, 6'd0, 1'b0, "final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Main control state machine for the multi-cycle MIPS CPU. It sits directly upstream of the ALU control decoder. It takes the opcode field from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback. In each state it drives every datapath enable and mux select, including the 2-bit ALUOp that the ALU control decoder turns into ALUCtrl. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Op  in  6  opcode field of the instruction register, IR[31:26]; stable from the cycle after the IRWrite edge.
- MemReady  in  1  memory completes the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls.
- ALUOp  out  2  to the ALU control decoder: 00 add, 01 subtract, 10 use Funct, 11 AND.
- ALUSrcB, PCSource  out  2 each  mux selects.
- State  out  4  current state encoding, for debug.
- InstrDone  out  1  one-cycle pulse in the final cycle of a retired instruction.
- Illegal  out  1  one-cycle pulse in DECODE when Op is unsupported.

## Operation
- Supported opcodes:
  - R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5.
  - EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11.
  - Encodings 12–15 are unreachable; if entered, they go to FETCH on the next edge with all outputs 0.
- Outputs are Moore-decoded from State, except IRWrite and PCWrite in FETCH. Any output not listed for a state is 0.
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
    - lw or sw → MEMADR.
    - R-type → EXEC.
    - beq → BRANCH.
    - j → JUMP.
    - addi or andi → IEXEC.
    - Any other opcode → FETCH, with Illegal=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw → MEMRD, sw → MEMWR.
  - MEMRD: MemRead=1, IorD=1. Held until MemReady=1, then → MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. → FETCH, InstrDone=1.
  - MEMWR: MemWrite=1, IorD=1. Held until MemReady=1, then → FETCH; InstrDone=1 in that cycle.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. → ALUWB.
  - ALUWB: RegWrite=1, RegDst=1. → FETCH, InstrDone=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH, InstrDone=1.
  - JUMP: PCWrite=1, PCSource=10. → FETCH, InstrDone=1.
  - IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi. → IWB.
  - IWB: RegWrite=1, RegDst=0, MemtoReg=0. → FETCH, InstrDone=1.
- The datapath qualifies PCWriteCond with the ALU Zero flag; Zero is not an input here.

## Timing
- Reset:
  - rst_n low forces State=FETCH immediately, without waiting for a clock edge.
  - While rst_n is low, IRWrite, PCWrite and InstrDone are forced to 0.
  - Other outputs show the FETCH decode: MemRead=1, ALUSrcB=01, every other output 0.
- Reset mid-operation: rst_n low in any state aborts the instruction. No further RegWrite or MemWrite is asserted. Execution resumes in FETCH on the first edge after rst_n goes high.
- Cycles from FETCH entry back to FETCH, with MemReady always 1:
  - beq, j: 3.
  - R-type, sw, addi, andi: 4.
  - lw: 5.
  - Illegal opcode: 2.
- Each cycle MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. All other outputs hold during the stall.
- IRWrite and PCWrite fire exactly once per fetch, in the MemReady=1 cycle.
- MemWrite stays asserted for every cycle of MEMWR, including stall cycles.
- Op is sampled only in DECODE, MEMADR and IEXEC. It may change in other states without effect.

## Test plan
- Reset: rst_n=0 asynchronously mid-EXEC → State=0 with no clock edge, IRWrite=0, RegWrite=0. After release with MemReady=1, the next edge gives State=1.
- R-type, Op=000000, MemReady=1: State sequence 0,1,6,7,0. ALUOp=10 only in state 6. RegWrite=RegDst=1 only in state 7. InstrDone pulses in state 7.
- lw, Op=100011, MemReady low for 2 cycles in FETCH and 3 in MEMRD: sequence 0,0,0,1,2,3,3,3,3,4,0, i.e. 11 cycles. IRWrite pulses once. MemtoReg=1 in state 4.
- beq, Op=000100: sequence 0,1,8,0. In state 8: ALUOp=01, PCWriteCond=1, PCSource=01, PCWrite=0.
- andi, Op=001100, then addi, Op=001000: ALUOp=11 in IEXEC for andi, 00 for addi. RegWrite=1, RegDst=0 in IWB for both.
- Illegal opcode Op=111111: sequence 0,1,0. Illegal pulses in state 1. No RegWrite, MemWrite or InstrDone.
